// File: rtl/cmprs_pkg.sv
// Shared types and constants for the beat RLE compressor.
// Header rewrite option: CMPRS_TOS_REWRITE_EN (consumed by beat_rle_compressor).
package cmprs_pkg;

    typedef enum logic [1:0] {
        HDR,
        PASS,
        COMP
    } state_e;

    localparam int ETYPE_LO = 12;
    localparam int ETYPE_HI = 13;
    localparam int TOS      = 15;
    localparam int PROTO    = 23;

    localparam logic [15:0] IPV4       = 16'h0800;
    localparam logic [7:0]  TCP        = 8'h06;
    localparam logic [31:0] COUNT_KEEP = 32'h0000_0001;

endpackage

// File: rtl/cmprs_hdr_classify.sv
// Decides from the first beat whether a packet is IPv4/TCP with the
// compression TOS value. Purely combinational.
module cmprs_hdr_classify
    import cmprs_pkg::*;
#(
    parameter int         DATA_WIDTH = 256,
    parameter logic [7:0] MATCH_TOS  = 8'h28
) (
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic                  qualify
);

    // Only four header bytes matter; the rest of the beat is ignored.
    logic unused_bits;
    assign unused_bits = ^data_in;

    // Ethertype, TOS and protocol must all match.
    always_comb begin
        qualify = (data_in[8*ETYPE_LO +: 8] == IPV4[15:8])
               && (data_in[8*ETYPE_HI +: 8] == IPV4[7:0])
               && (data_in[8*TOS +: 8]      == MATCH_TOS)
               && (data_in[8*PROTO +: 8]    == TCP);
    end

endmodule

// File: rtl/beat_rle_compressor.sv
// AXI-Stream beat-level run-length compressor for IPv4/TCP payloads.
// Define CMPRS_TOS_REWRITE_EN to mark compressed headers with MARK_TOS.
module beat_rle_compressor
    import cmprs_pkg::*;
#(
    parameter int         DATA_WIDTH = 256,
    parameter int         KEEP_WIDTH = DATA_WIDTH / 8,
    parameter logic [7:0] MATCH_TOS  = 8'h28,
    parameter logic [7:0] MARK_TOS   = 8'h29,
    parameter int         MAX_RUN    = 256
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  tvalid_in,
    input  logic                  tlast_in,
    input  logic                  tready_in,
    input  logic [KEEP_WIDTH-1:0] tkeep_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  tvalid_out,
    output logic                  tlast_out,
    output logic                  tready_out,
    output logic [KEEP_WIDTH-1:0] tkeep_out
);

    localparam int CW = $clog2(MAX_RUN);
    localparam logic [CW-1:0] C_MAX = CW'(MAX_RUN - 1);
    localparam logic [KEEP_WIDTH-1:0] KEEP_ALL = '1;

`ifdef CMPRS_TOS_REWRITE_EN
    localparam bit TOS_REWRITE = 1'b1;
`else
    localparam bit TOS_REWRITE = 1'b0;
`endif

    state_e state_q, state_d;

    logic [DATA_WIDTH-1:0] h_data_q, h_data_d;
    logic [KEEP_WIDTH-1:0] h_keep_q, h_keep_d;
    logic                  h_vld_q, h_vld_d;
    logic                  h_last_q, h_last_d;
    logic [CW-1:0]         c_q, c_d;
    logic                  cnt_pend_q, cnt_pend_d;
    logic [CW-1:0]         cnt_val_q, cnt_val_d;

    logic [DATA_WIDTH-1:0] o_data_q, o_data_d;
    logic [KEEP_WIDTH-1:0] o_keep_q, o_keep_d;
    logic                  o_vld_q, o_vld_d;
    logic                  o_last_q, o_last_d;

    logic                  qualify;
    logic                  flush;
    logic                  out_free;
    logic                  acc;
    logic                  match;
    logic [DATA_WIDTH-1:0] hdr_data;

    cmprs_hdr_classify #(
        .DATA_WIDTH (DATA_WIDTH),
        .MATCH_TOS  (MATCH_TOS)
    ) u_classify (
        .data_in (data_in),
        .qualify (qualify)
    );

    // Flush covers the trailing count beat and the held last beat.
    assign flush    = cnt_pend_q || (h_vld_q && h_last_q);
    assign out_free = !o_vld_q || tready_in;
    assign tready_out = reset && tready_in && !flush;
    assign acc      = tvalid_in && tready_out;

    assign match = (&tkeep_in) && !tlast_in && h_vld_q && (&h_keep_q)
                && (data_in == h_data_q) && (c_q < C_MAX);

    assign data_out   = o_data_q;
    assign tkeep_out  = o_keep_q;
    assign tvalid_out = o_vld_q;
    assign tlast_out  = o_last_q;

    // Header image sent downstream; multi-beat qualifying headers get marked.
    always_comb begin
        hdr_data = data_in;
        if (TOS_REWRITE && qualify && !tlast_in)
            hdr_data[8*TOS +: 8] = MARK_TOS;
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= HDR;
        else        state_q <= state_d;
    end

    // FSM next state: classify on the header, return on the last beat.
    always_comb begin
        state_d = state_q;
        if (acc) begin
            unique case (state_q)
                HDR: begin
                    if (!tlast_in) state_d = qualify ? COMP : PASS;
                end
                PASS, COMP: begin
                    if (tlast_in) state_d = HDR;
                end
                default: state_d = HDR;
            endcase
        end
    end

    // Datapath: hold register, run counter and output register loading.
    always_comb begin
        h_data_d   = h_data_q;
        h_keep_d   = h_keep_q;
        h_vld_d    = h_vld_q;
        h_last_d   = h_last_q;
        c_d        = c_q;
        cnt_pend_d = cnt_pend_q;
        cnt_val_d  = cnt_val_q;
        o_data_d   = o_data_q;
        o_keep_d   = o_keep_q;
        o_vld_d    = o_vld_q;
        o_last_d   = o_last_q;

        if (out_free) o_vld_d = 1'b0;

        if (flush && out_free) begin
            o_vld_d  = 1'b1;
            if (cnt_pend_q) begin
                o_data_d   = DATA_WIDTH'(cnt_val_q);
                o_keep_d   = KEEP_WIDTH'(COUNT_KEEP);
                o_last_d   = 1'b0;
                cnt_pend_d = 1'b0;
            end else begin
                o_data_d = h_data_q;
                o_keep_d = h_keep_q;
                o_last_d = 1'b1;
                h_vld_d  = 1'b0;
                h_last_d = 1'b0;
            end
        end else if (acc) begin
            if (state_q != COMP) begin
                o_vld_d  = 1'b1;
                o_data_d = (state_q == HDR) ? hdr_data : data_in;
                o_keep_d = tkeep_in;
                o_last_d = tlast_in;
            end else if (match) begin
                c_d = c_q + CW'(1);
            end else begin
                if (h_vld_q) begin
                    o_vld_d  = 1'b1;
                    o_data_d = h_data_q;
                    o_keep_d = KEEP_ALL;
                    o_last_d = 1'b0;
                    if (c_q != '0) begin
                        cnt_pend_d = 1'b1;
                        cnt_val_d  = c_q;
                    end
                end
                h_data_d = data_in;
                h_keep_d = tkeep_in;
                h_vld_d  = 1'b1;
                h_last_d = tlast_in;
                c_d      = '0;
            end
        end
    end

    // Datapath registers; reset discards any held beat and pending output.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            h_data_q   <= '0;
            h_keep_q   <= '0;
            h_vld_q    <= 1'b0;
            h_last_q   <= 1'b0;
            c_q        <= '0;
            cnt_pend_q <= 1'b0;
            cnt_val_q  <= '0;
            o_data_q   <= '0;
            o_keep_q   <= '0;
            o_vld_q    <= 1'b0;
            o_last_q   <= 1'b0;
        end else begin
            h_data_q   <= h_data_d;
            h_keep_q   <= h_keep_d;
            h_vld_q    <= h_vld_d;
            h_last_q   <= h_last_d;
            c_q        <= c_d;
            cnt_pend_q <= cnt_pend_d;
            cnt_val_q  <= cnt_val_d;
            o_data_q   <= o_data_d;
            o_keep_q   <= o_keep_d;
            o_vld_q    <= o_vld_d;
            o_last_q   <= o_last_d;
        end
    end

endmodule

// File: tb/tb_beat_rle_compressor.sv
// Testbench for beat_rle_compressor: cycle table for directed cases,
// then random packets checked against a run-based packet model.
module tb_beat_rle_compressor;

    localparam int DW   = 256;
    localparam int KW   = 32;
    localparam int MAXR = 256;
    localparam int XW   = DW + KW + 3;

    logic          clk = 1'b0;
    logic          reset;
    logic [DW-1:0] data_in;
    logic          tvalid_in;
    logic          tlast_in;
    logic          tready_in;
    logic [KW-1:0] tkeep_in;
    logic [DW-1:0] data_out;
    logic          tvalid_out;
    logic          tlast_out;
    logic          tready_out;
    logic [KW-1:0] tkeep_out;

    always #5 clk = ~clk;

    beat_rle_compressor dut (
        .clk        (clk),
        .reset      (reset),
        .data_in    (data_in),
        .tvalid_in  (tvalid_in),
        .tlast_in   (tlast_in),
        .tready_in  (tready_in),
        .tkeep_in   (tkeep_in),
        .data_out   (data_out),
        .tvalid_out (tvalid_out),
        .tlast_out  (tlast_out),
        .tready_out (tready_out),
        .tkeep_out  (tkeep_out)
    );

    typedef struct {
        logic          rs;
        logic          v;
        logic          l;
        logic [KW-1:0] k;
        logic [DW-1:0] d;
        logic          rin;
        logic          ev;
        logic          el;
        logic [KW-1:0] ek;
        logic [DW-1:0] ed;
        logic          erdy;
    } vec_t;

    typedef struct {
        logic [DW-1:0] d;
        logic [KW-1:0] k;
        logic          l;
    } beat_t;

    vec_t  tab[$];
    beat_t pkt[$];
    beat_t inq[$];
    beat_t expq[$];

    int nvec = 0;
    int nerr = 0;

    logic [DW-1:0] FF, Z, T, X, Y, H0, H1, H2, H2x;
    logic [DW-1:0] pool [3];
    logic [KW-1:0] ALL, TK;

    function automatic void chk(string nm, logic [XW-1:0] act, logic [XW-1:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endfunction

    function automatic logic [DW-1:0] mk_hdr(logic [7:0] b12, logic [7:0] b13,
                                             logic [7:0] tos, logic [7:0] pr);
        logic [DW-1:0] d;
        for (int k = 0; k < KW; k++) d[8*k +: 8] = 8'(k * 7 + 3);
        d[8*12 +: 8] = b12;
        d[8*13 +: 8] = b13;
        d[8*15 +: 8] = tos;
        d[8*23 +: 8] = pr;
        return d;
    endfunction

    function automatic logic [DW-1:0] exp_hdr(logic [DW-1:0] d);
        logic [DW-1:0] r;
        r = d;
`ifdef CMPRS_TOS_REWRITE_EN
        r[8*15 +: 8] = 8'h29;
`endif
        return r;
    endfunction

    function automatic logic [DW-1:0] cnt(int c);
        return DW'(c);
    endfunction

    function automatic void add(logic rs, logic v, logic l, logic [KW-1:0] k,
                                logic [DW-1:0] d, logic rin, logic ev, logic el,
                                logic [KW-1:0] ek, logic [DW-1:0] ed, logic erdy);
        vec_t r;
        r.rs = rs; r.v = v; r.l = l; r.k = k; r.d = d; r.rin = rin;
        r.ev = ev; r.el = el; r.ek = ek; r.ed = ed; r.erdy = erdy;
        tab.push_back(r);
    endfunction

    function automatic bit qualifies(logic [DW-1:0] d);
        return d[8*12 +: 8] == 8'h08 && d[8*13 +: 8] == 8'h00
            && d[8*15 +: 8] == 8'h28 && d[8*23 +: 8] == 8'h06;
    endfunction

    // Packet-level model: payload collapsed into runs of equal full beats.
    function automatic void model_pkt();
        int n;
        int i;
        int run;
        beat_t b;
        n = pkt.size();
        foreach (pkt[j]) inq.push_back(pkt[j]);
        if (n == 1 || !qualifies(pkt[0].d)) begin
            foreach (pkt[j]) expq.push_back(pkt[j]);
            return;
        end
        b = pkt[0];
        b.d = exp_hdr(b.d);
        expq.push_back(b);
        i = 1;
        while (i < n - 1) begin
            run = 1;
            while (i + run < n - 1 && run < MAXR && (&pkt[i].k)
                   && (&pkt[i+run].k) && pkt[i+run].d == pkt[i].d)
                run++;
            b.d = pkt[i].d; b.k = '1; b.l = 1'b0;
            expq.push_back(b);
            if (run > 1) begin
                b.d = cnt(run - 1); b.k = 32'h1; b.l = 1'b0;
                expq.push_back(b);
            end
            i += run;
        end
        expq.push_back(pkt[n-1]);
    endfunction

    function automatic void gen_pkt(int n, int kind, bit same);
        beat_t b;
        logic [7:0] b12, b13, tos, pr;
        b12 = 8'h08; b13 = 8'h00; tos = 8'h28; pr = 8'h06;
        case (kind)
            1: tos = 8'h27;
            2: begin b12 = 8'h86; b13 = 8'hDD; end
            3: pr = 8'h11;
            default: ;
        endcase
        pkt.delete();
        b.d = mk_hdr(b12, b13, tos, pr);
        b.d[31:0] = $urandom();
        b.k = '1;
        b.l = (n == 1);
        pkt.push_back(b);
        for (int j = 1; j < n; j++) begin
            b.d = same ? pool[0] : pool[$urandom_range(0, 2)];
            b.k = '1;
            b.l = (j == n - 1);
            if (b.l) begin
                b.k = $urandom();
                if (b.k == '0) b.k = 32'h1;
            end
            pkt.push_back(b);
        end
        model_pkt();
    endfunction

    task automatic run_table();
        logic [XW-1:0] act, exp;
        for (int i = 0; i < tab.size(); i++) begin
            @(negedge clk);
            reset     = tab[i].rs;
            tvalid_in = tab[i].v;
            tlast_in  = tab[i].l;
            tkeep_in  = tab[i].k;
            data_in   = tab[i].d;
            tready_in = tab[i].rin;
            #1;
            act = {tvalid_out, tready_out, 289'(0)};
            exp = {tab[i].ev, tab[i].erdy, 289'(0)};
            if (tab[i].ev) begin
                act[DW+KW:0] = {tlast_out, tkeep_out, data_out};
                exp[DW+KW:0] = {tab[i].el, tab[i].ek, tab[i].ed};
            end
            chk($sformatf("row%0d", i), act, exp);
        end
    endtask

    task automatic run_random();
        int            budget;
        bit            acc;
        bit            hold;
        logic [XW-1:0] saved;
        beat_t         e;
        budget = 0;
        acc = 1'b0;
        hold = 1'b0;
        saved = '0;
        while ((inq.size() > 0 || expq.size() > 0) && budget < 20000) begin
            @(negedge clk);
            tready_in = ($urandom_range(0, 3) != 0);
            if (!(tvalid_in && !acc)) begin
                if (inq.size() > 0 && $urandom_range(0, 4) != 0) begin
                    tvalid_in = 1'b1;
                    data_in   = inq[0].d;
                    tkeep_in  = inq[0].k;
                    tlast_in  = inq[0].l;
                end else begin
                    tvalid_in = 1'b0;
                end
            end
            #1;
            if (hold)
                chk("stall_hold", {2'b00, tvalid_out, tlast_out, tkeep_out, data_out}, saved);
            if (tvalid_out && tready_in) begin
                if (expq.size() == 0) begin
                    chk("extra_beat", {tlast_out, tkeep_out, data_out}, '0);
                end else begin
                    e = expq.pop_front();
                    chk("rand_beat", {tlast_out, tkeep_out, data_out}, {e.l, e.k, e.d});
                end
            end
            hold  = tvalid_out && !tready_in;
            saved = {2'b00, tvalid_out, tlast_out, tkeep_out, data_out};
            acc   = tvalid_in && tready_out;
            if (acc) void'(inq.pop_front());
            budget++;
        end
        if (inq.size() > 0 || expq.size() > 0) begin
            nvec++;
            nerr++;
            $display("FAIL rand_timeout: got %0d/%0d beats left want 0/0",
                     inq.size(), expq.size());
        end
        @(negedge clk);
        tvalid_in = 1'b0;
        tready_in = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("rand_idle", {tvalid_out, tready_out}, 2'b01);
    endtask

    initial begin
        reset     = 1'b0;
        tvalid_in = 1'b0;
        tlast_in  = 1'b0;
        tready_in = 1'b1;
        tkeep_in  = '0;
        data_in   = '0;

        FF  = '1;
        Z   = '0;
        ALL = '1;
        TK  = 32'h0000_FFFF;
        T   = {128'h0, {128{1'b1}}};
        X   = {16'h85AB, {240{1'b1}}};
        Y   = {128'h0, 64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210};
        H0  = mk_hdr(8'h06, 8'h00, 8'h28, 8'h06);
        H1  = mk_hdr(8'h08, 8'h00, 8'h27, 8'h06);
        H2  = mk_hdr(8'h08, 8'h00, 8'h28, 8'h06);
        H2x = exp_hdr(H2);
        for (int i = 0; i < 3; i++)
            for (int w = 0; w < 8; w++) pool[i][32*w +: 32] = $urandom();

        repeat (2) @(negedge clk);
        #1;
        chk("rst_valid", XW'(tvalid_out), '0);
        chk("rst_ready", XW'(tready_out), '0);
        chk("rst_keep",  XW'(tkeep_out),  '0);
        chk("rst_data",  XW'(data_out),   '0);

        // non-IPv4 passthrough
        add(1, 1, 0, ALL, H0, 1,  0, 0, 0, Z, 1);
        add(1, 1, 1, TK,  T,  1,  1, 0, ALL, H0, 1);
        add(1, 0, 0, 0,   Z,  1,  1, 1, TK,  T,  1);
        add(1, 0, 0, 0,   Z,  1,  0, 0, 0,   Z,  1);
        // IPv4 with non-matching TOS
        add(1, 1, 0, ALL, H1, 1,  0, 0, 0,   Z,  1);
        add(1, 1, 0, ALL, FF, 1,  1, 0, ALL, H1, 1);
        add(1, 1, 0, ALL, FF, 1,  1, 0, ALL, FF, 1);
        add(1, 1, 0, ALL, FF, 1,  1, 0, ALL, FF, 1);
        add(1, 1, 1, TK,  T,  1,  1, 0, ALL, FF, 1);
        add(1, 0, 0, 0,   Z,  1,  1, 1, TK,  T,  1);
        add(1, 0, 0, 0,   Z,  1,  0, 0, 0,   Z,  1);
        // qualifying: three FF beats collapse to FF + count 2
        add(1, 1, 0, ALL, H2, 1,  0, 0, 0,   Z,   1);
        add(1, 1, 0, ALL, FF, 1,  1, 0, ALL, H2x, 1);
        add(1, 1, 0, ALL, FF, 1,  0, 0, 0,   Z,   1);
        add(1, 1, 0, ALL, FF, 1,  0, 0, 0,   Z,   1);
        add(1, 1, 1, TK,  T,  1,  0, 0, 0,   Z,   1);
        add(1, 0, 0, 0,   Z,  1,  1, 0, ALL, FF,  0);
        add(1, 0, 0, 0,   Z,  1,  1, 0, 32'h1, cnt(2), 0);
        add(1, 0, 0, 0,   Z,  1,  1, 1, TK,  T,   1);
        add(1, 0, 0, 0,   Z,  1,  0, 0, 0,   Z,   1);
        // run boundary: FF FF X Y
        add(1, 1, 0, ALL, H2, 1,  0, 0, 0,   Z,   1);
        add(1, 1, 0, ALL, FF, 1,  1, 0, ALL, H2x, 1);
        add(1, 1, 0, ALL, FF, 1,  0, 0, 0,   Z,   1);
        add(1, 1, 0, ALL, X,  1,  0, 0, 0,   Z,   1);
        add(1, 1, 1, TK,  Y,  1,  1, 0, ALL, FF,  0);
        add(1, 1, 1, TK,  Y,  1,  1, 0, 32'h1, cnt(1), 1);
        add(1, 0, 0, 0,   Z,  1,  1, 0, ALL, X,   0);
        add(1, 0, 0, 0,   Z,  1,  1, 1, TK,  Y,   1);
        add(1, 0, 0, 0,   Z,  1,  0, 0, 0,   Z,   1);
        // backpressure with header held, then during flush
        add(1, 1, 0, ALL, H2, 1,  0, 0, 0,   Z,   1);
        add(1, 1, 0, ALL, FF, 0,  1, 0, ALL, H2x, 0);
        add(1, 1, 0, ALL, FF, 0,  1, 0, ALL, H2x, 0);
        add(1, 1, 0, ALL, FF, 0,  1, 0, ALL, H2x, 0);
        add(1, 1, 0, ALL, FF, 1,  1, 0, ALL, H2x, 1);
        add(1, 1, 0, ALL, FF, 1,  0, 0, 0,   Z,   1);
        add(1, 1, 0, ALL, FF, 1,  0, 0, 0,   Z,   1);
        add(1, 1, 1, TK,  T,  1,  0, 0, 0,   Z,   1);
        add(1, 0, 0, 0,   Z,  0,  1, 0, ALL, FF,  0);
        add(1, 0, 0, 0,   Z,  1,  1, 0, ALL, FF,  0);
        add(1, 0, 0, 0,   Z,  1,  1, 0, 32'h1, cnt(2), 0);
        add(1, 0, 0, 0,   Z,  1,  1, 1, TK,  T,   1);
        add(1, 0, 0, 0,   Z,  1,  0, 0, 0,   Z,   1);
        // reset mid-packet, next beat is a header again
        add(1, 1, 0, ALL, H2, 1,  0, 0, 0,   Z,   1);
        add(1, 1, 0, ALL, FF, 1,  1, 0, ALL, H2x, 1);
        add(0, 1, 0, ALL, FF, 1,  0, 0, 0,   Z,   0);
        add(1, 1, 0, ALL, H0, 1,  0, 0, 0,   Z,   1);
        add(1, 1, 1, TK,  T,  1,  1, 0, ALL, H0,  1);
        add(1, 0, 0, 0,   Z,  1,  1, 1, TK,  T,   1);
        add(1, 0, 0, 0,   Z,  1,  0, 0, 0,   Z,   1);

        run_table();

        for (int p = 0; p < 40; p++) begin
            int k;
            k = $urandom_range(0, 4);
            gen_pkt($urandom_range(1, 10), (k == 4) ? 0 : k, 1'b0);
        end
        gen_pkt(300, 0, 1'b1);
        gen_pkt(2, 0, 1'b0);
        run_random();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
